// File: rtl/instr_mem_writer.sv
// instr_mem_writer: accepts 32-bit instruction words over a valid/ready
// handshake and writes them big-endian, one byte per cycle, into a
// byte-wide instruction memory. Back-to-back words stream with no idle gap.
// Optional feature macro: INSTR_WR_BOUNDS_EN rejects words whose four bytes
// would run past the top of memory (sets the sticky err flag instead).

module instr_mem_writer #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_addr,
  input  logic [31:0]       in_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_d,
  output logic              busy,
  output logic [15:0]       words_written,
  output logic              err
);

  typedef enum logic {
    IDLE,
    WR
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  lane;
  logic [1:0]  lane_next;
  logic        accept;
  logic        reject;
  logic        load;
  logic        advance;
  logic [31:0] data_q;

  // Address bits above the memory size are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^in_addr[31:ADDR_W];

`ifdef INSTR_WR_BOUNDS_EN
  // Highest start address whose four bytes still fit below the top of memory.
  localparam logic [ADDR_W-1:0] LAST_OK = ADDR_W'((2 ** ADDR_W) - 4);
`endif

  // Next-state, handshake and strobe decode; outputs depend only on state.
  always_comb begin
    state_next = state;
    lane_next  = lane;
    load       = 1'b0;
    advance    = 1'b0;
    in_ready   = (state == IDLE) || (lane == 2'd3);
    mem_we     = (state == WR);
    busy       = (state == WR);
    accept     = in_valid && in_ready;
`ifdef INSTR_WR_BOUNDS_EN
    reject     = in_addr[ADDR_W-1:0] > LAST_OK;
`else
    reject     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept && !reject) begin
          state_next = WR;
          lane_next  = 2'd0;
          load       = 1'b1;
        end
      end
      WR: begin
        if (lane != 2'd3) begin
          lane_next = lane + 2'd1;
          advance   = 1'b1;
        end else if (accept && !reject) begin
          lane_next = 2'd0;
          load      = 1'b1;
        end else begin
          state_next = IDLE;
          lane_next  = 2'd0;
        end
      end
      default: begin
        state_next = IDLE;
        lane_next  = 2'd0;
      end
    endcase
  end

  // State and lane registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lane  <= 2'd0;
    end else begin
      state <= state_next;
      lane  <= lane_next;
    end
  end

  // Byte datapath: load the MSB on accept, then shift out one byte per lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_a         <= '0;
      mem_d         <= 8'h00;
      data_q        <= 32'h0;
      words_written <= 16'h0;
      err           <= 1'b0;
    end else begin
      if (load) begin
        mem_a  <= in_addr[ADDR_W-1:0];
        mem_d  <= in_data[31:24];
        data_q <= {in_data[23:0], 8'h00};
      end else if (advance) begin
        mem_a  <= mem_a + 1'b1;
        mem_d  <= data_q[31:24];
        data_q <= {data_q[23:0], 8'h00};
      end
      if ((state == WR) && (lane == 2'd3)) begin
        words_written <= words_written + 16'd1;
      end
      if (accept && reject) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_writer.sv
// tb_instr_mem_writer: directed test of instr_mem_writer with hand-computed
// expected byte streams. Outputs are sampled and inputs driven on the
// falling clock edge.

module tb_instr_mem_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic        mem_we;
  logic [9:0]  mem_a;
  logic [7:0]  mem_d;
  logic        busy;
  logic [15:0] words_written;
  logic        err;

  int passed = 0;
  int total  = 0;

  instr_mem_writer #(.ADDR_W(10)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_addr       (in_addr),
    .in_data       (in_data),
    .mem_we        (mem_we),
    .mem_a         (mem_a),
    .mem_d         (mem_d),
    .busy          (busy),
    .words_written (words_written),
    .err           (err)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_addr  = 32'h0;
    in_data  = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] obs;
    logic [20:0] exp;
    do_reset();
    obs = {mem_we, busy, in_ready, mem_a, mem_d};
    exp = {1'b0, 1'b0, 1'b1, 10'h000, 8'h00};
    total++;
    if (obs !== exp) $display("[TB] FAIL reset_outputs: got %h expected %h", obs, exp);
    else passed++;
    total++;
    if ({err, words_written} !== 17'h0)
      $display("[TB] FAIL reset_counters: got err=%b words=%0d expected err=0 words=0", err, words_written);
    else passed++;
  endtask

  task automatic test_single_word();
    logic [20:0] obs;
    logic [20:0] exp;
    logic [31:0] word;
    word = 32'hDEADBEEF;
    do_reset();
    in_valid = 1'b1;
    in_addr  = 32'h0000_0010;
    in_data  = word;
    @(negedge clk);
    in_valid = 1'b0;
    for (int l = 0; l < 4; l++) begin
      obs = {mem_we, busy, in_ready, mem_a, mem_d};
      exp = {1'b1, 1'b1, (l == 3), 10'h010 + 10'(l), word[31 - 8*l -: 8]};
      total++;
      if (obs !== exp) $display("[TB] FAIL single_lane%0d: got %h expected %h", l, obs, exp);
      else passed++;
      @(negedge clk);
    end
    obs = {mem_we, busy, in_ready, mem_a, mem_d};
    exp = {1'b0, 1'b0, 1'b1, 10'h013, 8'hEF};
    total++;
    if (obs !== exp) $display("[TB] FAIL single_idle_hold: got %h expected %h", obs, exp);
    else passed++;
    total++;
    if (words_written !== 16'd1) $display("[TB] FAIL single_count: got %0d expected 1", words_written);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [20:0] obs;
    logic [20:0] exp;
    logic [31:0] words [3];
    logic [9:0]  addrs [3];
    words[0] = 32'h11111111; addrs[0] = 10'h000;
    words[1] = 32'h22222222; addrs[1] = 10'h004;
    words[2] = 32'h33333333; addrs[2] = 10'h008;
    do_reset();
    in_valid = 1'b1;
    in_addr  = {22'h0, addrs[0]};
    in_data  = words[0];
    @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      for (int l = 0; l < 4; l++) begin
        obs = {mem_we, busy, in_ready, mem_a, mem_d};
        exp = {1'b1, 1'b1, (l == 3), addrs[w] + 10'(l), words[w][31 - 8*l -: 8]};
        total++;
        if (obs !== exp) $display("[TB] FAIL b2b_w%0d_lane%0d: got %h expected %h", w, l, obs, exp);
        else passed++;
        if (l == 0) begin
          if (w < 2) begin
            in_addr = {22'h0, addrs[w + 1]};
            in_data = words[w + 1];
          end else begin
            in_valid = 1'b0;
          end
        end
        @(negedge clk);
      end
    end
    total++;
    if ({mem_we, busy, in_ready, words_written} !== {3'b001, 16'd3})
      $display("[TB] FAIL b2b_end: got we=%b busy=%b ready=%b words=%0d expected 0 0 1 3",
               mem_we, busy, in_ready, words_written);
    else passed++;
  endtask

  task automatic test_wrap();
    logic [20:0] obs;
    logic [20:0] exp;
    logic [31:0] word;
    word = 32'hA1B2C3D4;
    do_reset();
    in_valid = 1'b1;
    in_addr  = 32'h0000_03FE;
    in_data  = word;
    @(negedge clk);
    in_valid = 1'b0;
`ifdef INSTR_WR_BOUNDS_EN
    obs = {mem_we, busy, in_ready, mem_a, mem_d};
    exp = {1'b0, 1'b0, 1'b1, 10'h000, 8'h00};
    total++;
    if (obs !== exp) $display("[TB] FAIL bounds_reject: got %h expected %h", obs, exp);
    else passed++;
    total++;
    if ({err, words_written} !== {1'b1, 16'd0})
      $display("[TB] FAIL bounds_err: got err=%b words=%0d expected err=1 words=0", err, words_written);
    else passed++;
    word     = 32'h55667788;
    in_valid = 1'b1;
    in_addr  = 32'h0000_0020;
    in_data  = word;
    @(negedge clk);
    in_valid = 1'b0;
    for (int l = 0; l < 4; l++) begin
      obs = {mem_we, busy, in_ready, mem_a, mem_d};
      exp = {1'b1, 1'b1, (l == 3), 10'h020 + 10'(l), word[31 - 8*l -: 8]};
      total++;
      if (obs !== exp) $display("[TB] FAIL bounds_next_lane%0d: got %h expected %h", l, obs, exp);
      else passed++;
      @(negedge clk);
    end
    total++;
    if ({err, words_written} !== {1'b1, 16'd1})
      $display("[TB] FAIL bounds_sticky: got err=%b words=%0d expected err=1 words=1", err, words_written);
    else passed++;
`else
    for (int l = 0; l < 4; l++) begin
      obs = {mem_we, busy, in_ready, mem_a, mem_d};
      exp = {1'b1, 1'b1, (l == 3), 10'h3FE + 10'(l), word[31 - 8*l -: 8]};
      total++;
      if (obs !== exp) $display("[TB] FAIL wrap_lane%0d: got %h expected %h", l, obs, exp);
      else passed++;
      @(negedge clk);
    end
    total++;
    if ({err, words_written, mem_we} !== {1'b0, 16'd1, 1'b0})
      $display("[TB] FAIL wrap_end: got err=%b words=%0d we=%b expected err=0 words=1 we=0",
               err, words_written, mem_we);
    else passed++;
`endif
  endtask

  task automatic test_reset_mid_word();
    logic [20:0] obs;
    logic [20:0] exp;
    do_reset();
    in_valid = 1'b1;
    in_addr  = 32'h0000_0040;
    in_data  = 32'h01234567;
    @(negedge clk);
    obs = {mem_we, busy, in_ready, mem_a, mem_d};
    exp = {1'b1, 1'b1, 1'b0, 10'h040, 8'h01};
    total++;
    if (obs !== exp) $display("[TB] FAIL midrst_lane0: got %h expected %h", obs, exp);
    else passed++;
    rst      = 1'b1;
    in_valid = 1'b1;
    in_addr  = 32'h0000_0080;
    in_data  = 32'h0BADF00D;
    @(negedge clk);
    obs = {mem_we, busy, in_ready, mem_a, mem_d};
    exp = {1'b0, 1'b0, 1'b1, 10'h000, 8'h00};
    total++;
    if (obs !== exp) $display("[TB] FAIL midrst_abandon: got %h expected %h", obs, exp);
    else passed++;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({mem_we, busy, in_ready, words_written} !== {3'b001, 16'd0})
      $display("[TB] FAIL midrst_after: got we=%b busy=%b ready=%b words=%0d expected 0 0 1 0",
               mem_we, busy, in_ready, words_written);
    else passed++;
  endtask

  // Run every scenario in order and report.
  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_addr  = 32'h0;
    in_data  = 32'h0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_wrap();
    test_reset_mid_word();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
